// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-side branch predictor: 2-bit counter
// encodings, default table geometry and the counter values used at reset
// and on allocation.
package bp_pkg;

    localparam int BP_IDX_BITS_DEF = 6;
    localparam int BP_TAG_BITS_DEF = 24;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Fresh entries start weakly not-taken; newly allocated ones weakly taken.
    localparam logic [1:0] CTR_RESET_VAL = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC_VAL = CTR_WT;

endpackage : bp_pkg

// File: rtl/bp_sat_ctr.sv
// Next-state logic for one 2-bit saturating direction counter.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step toward the resolved direction, holding at either extreme.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule : bp_sat_ctr

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit direction counter per entry. Lookup is
// combinational from pred_pc; resolved branches train the table on the clock
// edge. Optional saturating statistics counters are built only when
// BP_PERF_CNT_EN is defined; otherwise the perf outputs read 0.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_BITS = BP_IDX_BITS_DEF,
    parameter int TAG_BITS = BP_TAG_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pred_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic        bp_clear,
    output logic [31:0] perf_updates,
    output logic [31:0] perf_mispredicts
);

    localparam int ENTRIES = 1 << IDX_BITS;

    if (IDX_BITS + TAG_BITS + 2 != 32) begin : g_bad_cfg
        $error("branch_predictor: IDX_BITS + TAG_BITS + 2 must equal 32");
    end

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] pred_idx;
    logic [TAG_BITS-1:0] pred_tag;
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_hit;
    logic [1:0]          upd_ctr_next;

    // PCs are word aligned; the two low bits never select anything.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0]};

    assign pred_idx = pred_pc[IDX_BITS+1:2];
    assign pred_tag = pred_pc[IDX_BITS+2 +: TAG_BITS];
    assign upd_idx  = upd_pc[IDX_BITS+1:2];
    assign upd_tag  = upd_pc[IDX_BITS+2 +: TAG_BITS];

    // Lookup reads the pre-edge state only; there is no bypass from the
    // update port, so a same-cycle update is visible one cycle later.
    always_comb begin
        pred_hit    = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
        pred_taken  = pred_hit && ctr_q[pred_idx][1];
        pred_target = pred_taken ? target_q[pred_idx] : (pred_pc + 32'd4);
    end

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    bp_sat_ctr u_sat_ctr (
        .ctr      (ctr_q[upd_idx]),
        .taken    (upd_taken),
        .ctr_next (upd_ctr_next)
    );

    // Table training: hits adjust the counter (and refresh the target when
    // taken), taken misses evict and allocate, bp_clear overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET_VAL;
            end
        end else if (bp_clear) begin
            valid_q <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= upd_ctr_next;
                if (upd_taken) begin
                    target_q[upd_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= CTR_ALLOC_VAL;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_upd_q;
    logic [31:0] perf_mis_q;

    // Statistics count every resolved branch regardless of bp_clear and
    // stick at all-ones instead of wrapping; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_upd_q <= '0;
            perf_mis_q <= '0;
        end else if (upd_valid) begin
            if (perf_upd_q != 32'hFFFF_FFFF) begin
                perf_upd_q <= perf_upd_q + 32'd1;
            end
            if ((upd_taken != upd_pred_taken) && (perf_mis_q != 32'hFFFF_FFFF)) begin
                perf_mis_q <= perf_mis_q + 32'd1;
            end
        end
    end

    assign perf_updates     = perf_upd_q;
    assign perf_mispredicts = perf_mis_q;
`else
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;
    assign perf_updates      = '0;
    assign perf_mispredicts  = '0;
`endif

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus computes the expected
// lookup response from a table model and queues it; a monitor on the falling
// edge pops and compares against the DUT outputs.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic        bp_clear = 1'b0;
    logic [31:0] perf_updates;
    logic [31:0] perf_mispredicts;

    branch_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_pc          (pred_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .bp_clear         (bp_clear),
        .perf_updates     (perf_updates),
        .perf_mispredicts (perf_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [31:0] p_upd;
        logic [31:0] p_mis;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: 64-entry table, counter held as an integer 0..3.
    bit          m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_ctr   [64];
    longint      m_upd;
    longint      m_mis;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_upd = 0;
        m_mis = 0;
    endfunction

    task automatic check_val(input string nm, input string field,
                             input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, field, act, req);
        end
    endtask

    // One fetch cycle: drive inputs just after the rising edge, queue the
    // expected response, then advance the model past the coming edge.
    task automatic cycle(input string nm, input logic [31:0] ppc,
                         input bit uv, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utgt, input bit upt,
                         input bit clr, input bit rst);
        exp_t e;
        int   i;
        bit   h;
        @(posedge clk);
        #1;
        pred_pc        = ppc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        upd_pred_taken = upt;
        bp_clear       = clr;
        rst_n          = !rst;
        if (rst) model_reset();

        i = int'(ppc[7:2]);
        e.name   = nm;
        e.hit    = m_valid[i] && (m_tag[i] == ppc[31:8]);
        e.taken  = e.hit && (m_ctr[i] >= 2);
        e.target = e.taken ? m_tgt[i] : ppc + 32'd4;
`ifdef BP_PERF_CNT_EN
        e.p_upd  = 32'(m_upd);
        e.p_mis  = 32'(m_mis);
`else
        e.p_upd  = '0;
        e.p_mis  = '0;
`endif
        sb_q.push_back(e);

        if (!rst) begin
            if (uv) begin
                if (m_upd < 64'hFFFF_FFFF) m_upd++;
                if (ut != upt && m_mis < 64'hFFFF_FFFF) m_mis++;
            end
            if (clr) begin
                for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
            end else if (uv) begin
                i = int'(upc[7:2]);
                h = m_valid[i] && (m_tag[i] == upc[31:8]);
                if (h) begin
                    if (ut) begin
                        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                        m_tgt[i] = utgt;
                    end else begin
                        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                    end
                end else if (ut) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = upc[31:8];
                    m_tgt[i]   = utgt;
                    m_ctr[i]   = 2;
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
        if ($urandom_range(0, 7) == 0) p = p | 32'h8000_0000;
        return p;
    endfunction

    // Monitor: compare every queued expectation on the falling edge.
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check_val(mon_e.name, "hit",    {31'd0, pred_hit},   {31'd0, mon_e.hit});
                check_val(mon_e.name, "taken",  {31'd0, pred_taken}, {31'd0, mon_e.taken});
                check_val(mon_e.name, "target", pred_target,         mon_e.target);
                check_val(mon_e.name, "perf_upd", perf_updates,      mon_e.p_upd);
                check_val(mon_e.name, "perf_mis", perf_mispredicts,  mon_e.p_mis);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        // name, ppc, uv, upc, ut, utgt, upt, clr, rst
        cycle("reset",      32'h100,  0, 32'h0,   0, 32'h0,  0, 0, 1);
        cycle("idle",       32'h100,  0, 32'h0,   0, 32'h0,  0, 0, 0);
        // Same-cycle lookup and allocating update: miss now, hit next cycle.
        cycle("same_cyc",   32'h100,  1, 32'h100, 1, 32'h80, 0, 0, 0);
        cycle("alloc_hit",  32'h100,  0, 32'h0,   0, 32'h0,  0, 0, 0);
        cycle("other_tag",  32'h1100, 0, 32'h0,   0, 32'h0,  0, 0, 0);
        cycle("nt1",        32'h100,  1, 32'h100, 0, 32'h0,  1, 0, 0);
        cycle("nt2",        32'h100,  1, 32'h100, 0, 32'h0,  1, 0, 0);
        cycle("ctr_snt",    32'h100,  1, 32'h100, 0, 32'h0,  0, 0, 0);
        cycle("snt_sat",    32'h100,  0, 32'h0,   0, 32'h0,  0, 0, 0);
        for (int k = 0; k < 4; k++)
            cycle("tk_up",  32'h100,  1, 32'h100, 1, 32'h84, 0, 0, 0);
        cycle("st_sat",     32'h100,  1, 32'h100, 0, 32'h0,  0, 0, 0);
        cycle("st_minus1",  32'h100,  0, 32'h0,   0, 32'h0,  0, 0, 0);
        cycle("wrap_alloc", 32'h100,  1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, 0);
        cycle("wrap_hit",   32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        // Clear beats a simultaneous allocating update.
        cycle("clr_upd",    32'h200,  1, 32'h200, 1, 32'h300, 1, 1, 0);
        cycle("clr_200",    32'h200,  0, 32'h0,   0, 32'h0,  0, 0, 0);
        cycle("clr_100",    32'h100,  0, 32'h0,   0, 32'h0,  0, 0, 0);
        // Statistics burst, then reset while an update is in flight.
        cycle("perf_rst",   32'h100,  0, 32'h0,   0, 32'h0,  0, 0, 1);
        cycle("perf_u1",    32'h100,  1, 32'h100, 1, 32'h80, 1, 0, 0);
        cycle("perf_u2",    32'h100,  1, 32'h100, 0, 32'h0,  1, 0, 0);
        cycle("perf_u3",    32'h100,  1, 32'h104, 1, 32'h90, 0, 0, 0);
        cycle("perf_u4",    32'h104,  1, 32'h104, 0, 32'h0,  0, 0, 0);
        cycle("perf_u5",    32'h104,  1, 32'h108, 0, 32'h0,  0, 0, 0);
        cycle("perf_5_2",   32'h100,  1, 32'h100, 1, 32'h80, 1, 0, 0);
        cycle("mid_rst",    32'h100,  1, 32'h100, 1, 32'h80, 0, 0, 1);
        cycle("post_rst",   32'h100,  0, 32'h0,   0, 32'h0,  0, 0, 0);

        for (int k = 0; k < 400; k++) begin
            cycle("rand", rand_pc(),
                  ($urandom_range(0, 9) < 7), rand_pc(), 1'($urandom_range(0, 1)),
                  $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0));
        end

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_branch_predictor
